// File: rtl/sum_nk_reducer_pkg.sv
// sum_nk_pkg: shared types and width helpers for the sum_nk_reducer slice.
//   state_e      - reducer FSM states
//   ceil_div     - integer ceiling division
//   sum_width    - SW = W + clog2(N), the sum width that cannot overflow
//   accum_beats  - B = ceil(N/P), the accumulate beats
//   tree_levels  - L = clog2(P), the fold levels
//   cnt_width    - width of a counter holding 0..v-1 (at least 1 bit)
package sum_nk_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StTree  = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
    return w + $clog2(n);
  endfunction

  function automatic int unsigned accum_beats(input int unsigned n, input int unsigned p);
    return ceil_div(n, p);
  endfunction

  function automatic int unsigned tree_levels(input int unsigned p);
    return $clog2(p);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sum_nk_reducer_if.sv
// sum_nk_reducer_if: start/operand/result bundle of the reducer.
//   start  - request, master -> slave
//   nums   - N*W flattened operands, operand k at [k*W +: W]
//   busy   - high while accumulating or folding
//   done   - one-cycle result strobe
//   sum    - SW-bit result, held until the next done
interface sum_nk_reducer_if
  import sum_nk_pkg::*;
#(
  parameter int unsigned N = 50,
  parameter int unsigned W = 5
);
  localparam int unsigned SW = sum_width(N, W);

  logic              start;
  logic [N*W-1:0]    nums;
  logic              busy;
  logic              done;
  logic [SW-1:0]     sum;

  modport master (output start, output nums, input busy, input done, input sum);
  modport slave  (input start, input nums, output busy, output done, output sum);

endinterface

// File: rtl/sum_nk_lane_bank.sv
// sum_nk_lane_bank: P lane accumulators, each with one shared SW-bit adder.
//   clk, rst_n  - clock, async active-low reset
//   i_clear     - zero every accumulator (highest priority)
//   i_accum     - lane i adds operand i_beat*P + i (zero past N)
//   i_tree      - fold level over i_live partials: pair sums, odd tail passes through
//   i_beat      - current accumulate beat
//   i_live      - number of live partials in the current fold level
//   i_nums      - snapshot of the operands
//   o_acc0_d    - next value of lane 0, so the result can be taken on the final edge
module sum_nk_lane_bank
  import sum_nk_pkg::*;
#(
  parameter int unsigned N      = 50,
  parameter int unsigned W      = 5,
  parameter int unsigned P      = 9,
  parameter int unsigned SW     = 11,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned BW     = 3,
  parameter int unsigned MW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_accum,
  input  logic            i_tree,
  input  logic [BW-1:0]   i_beat,
  input  logic [MW-1:0]   i_live,
  input  logic [N*W-1:0]  i_nums,
  output logic [SW-1:0]   o_acc0_d
);

  logic [SW-1:0] w_acc  [P];
  logic [SW-1:0] w_next [P];

  for (genvar i = 0; i < P; i++) begin : g_lane
    localparam int Lo = 2 * i;
    localparam int Hi = 2 * i + 1;

    logic [SW-1:0] r_acc;
    logic [W-1:0]  w_op;
    logic [SW-1:0] w_op_ext;
    logic [SW-1:0] w_pair_lo;
    logic [SW-1:0] w_pair_hi;
    logic [SW-1:0] w_add_a;
    logic [SW-1:0] w_add_b;
    logic [SW-1:0] w_add;
    logic [SW-1:0] w_lane_d;

    // Operand select for this lane's beat; indices past N stay zero.
    always_comb begin
      w_op = '0;
      for (int k = 0; k < int'(N); k++) begin
        if (int'(i_beat) * int'(P) + i == k) w_op = i_nums[k*W +: W];
      end
    end

    if (SIGNED) begin : g_sext
      assign w_op_ext = SW'($signed(w_op));
    end else begin : g_zext
      assign w_op_ext = SW'(w_op);
    end

    if (Lo < int'(P)) begin : g_lo
      assign w_pair_lo = w_acc[Lo];
    end else begin : g_lo_none
      assign w_pair_lo = '0;
    end

    if (Hi < int'(P)) begin : g_hi
      assign w_pair_hi = w_acc[Hi];
    end else begin : g_hi_none
      assign w_pair_hi = '0;
    end

    always_comb begin
      w_add_a = r_acc;
      w_add_b = '0;
      if (!i_accum && i_tree) begin
        w_add_a = w_pair_lo;
        w_add_b = w_pair_hi;
      end else if (i_accum) begin
        w_add_b = w_op_ext;
      end
    end

    assign w_add = w_add_a + w_add_b;

    always_comb begin
      w_lane_d = r_acc;
      if (i_clear) begin
        w_lane_d = '0;
      end else if (i_accum) begin
        w_lane_d = w_add;
      end else if (i_tree) begin
        if (Hi < int'(i_live)) begin
          w_lane_d = w_add;
        end else if (Lo + 1 == int'(i_live)) begin
          // Odd tail moves down unchanged.
          w_lane_d = w_pair_lo;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else        r_acc <= w_lane_d;
    end

    assign w_acc[i]  = r_acc;
    assign w_next[i] = w_lane_d;
  end

  assign o_acc0_d = w_next[0];

endmodule

// File: rtl/sum_nk_reducer.sv
// sum_nk_reducer: sums N W-bit operands with P shared adders.
//   clk, rst_n - clock, async active-low reset
//   io_bus     - slave side of sum_nk_reducer_if (start, nums in; busy, done, sum out)
// A start in IDLE or DONE snapshots nums, then B accumulate beats and L fold levels
// run; done pulses for one cycle with sum valid B+L edges after the accepting edge.
module sum_nk_reducer
  import sum_nk_pkg::*;
#(
  parameter int unsigned N      = 50,
  parameter int unsigned W      = 5,
  parameter int unsigned P      = 9,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sum_nk_reducer_if.slave   io_bus
);

  localparam int unsigned SW = sum_width(N, W);
  localparam int unsigned B  = accum_beats(N, P);
  localparam int unsigned L  = tree_levels(P);
  localparam int unsigned BW = cnt_width(B);
  localparam int unsigned LW = cnt_width(L);
  localparam int unsigned MW = $clog2(P + 1);

  localparam logic [BW-1:0] BeatLast  = BW'(B - 1);
  localparam logic [LW-1:0] LevelLast = (L > 0) ? LW'(L - 1) : '0;
  localparam logic [MW-1:0] LiveAll   = MW'(P);

  state_e         r_state, w_state_d;
  logic [BW-1:0]  r_beat, w_beat_d;
  logic [LW-1:0]  r_level, w_level_d;
  logic [MW-1:0]  r_live, w_live_d;
  logic [N*W-1:0] r_nums;
  logic [SW-1:0]  r_sum;

  logic           w_accept;
  logic           w_accum;
  logic           w_tree;
  logic           w_load_sum;
  logic [SW-1:0]  w_acc0_d;

  always_comb begin
    w_state_d  = r_state;
    w_beat_d   = r_beat;
    w_level_d  = r_level;
    w_live_d   = r_live;
    w_accept   = 1'b0;
    w_accum    = 1'b0;
    w_tree     = 1'b0;
    w_load_sum = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_accept  = 1'b1;
          w_beat_d  = '0;
          w_state_d = StAccum;
        end
      end
      StAccum: begin
        w_accum = 1'b1;
        if (r_beat == BeatLast) begin
          w_beat_d  = '0;
          w_level_d = '0;
          w_live_d  = LiveAll;
          if (L == 0) begin
            w_state_d  = StDone;
            w_load_sum = 1'b1;
          end else begin
            w_state_d = StTree;
          end
        end else begin
          w_beat_d = r_beat + 1'b1;
        end
      end
      StTree: begin
        w_tree   = 1'b1;
        // ceil(m/2) without widening r_live
        w_live_d = (r_live >> 1) + MW'(r_live[0]);
        if (r_level == LevelLast) begin
          w_level_d  = '0;
          w_state_d  = StDone;
          w_load_sum = 1'b1;
        end else begin
          w_level_d = r_level + 1'b1;
        end
      end
      StDone: begin
        if (io_bus.start) begin
          w_accept  = 1'b1;
          w_beat_d  = '0;
          w_state_d = StAccum;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_level <= '0;
      r_live  <= '0;
      r_nums  <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_level <= w_level_d;
      r_live  <= w_live_d;
      if (w_accept)   r_nums <= io_bus.nums;
      if (w_load_sum) r_sum  <= w_acc0_d;
    end
  end

  sum_nk_lane_bank #(
    .N      (N),
    .W      (W),
    .P      (P),
    .SW     (SW),
    .SIGNED (SIGNED),
    .BW     (BW),
    .MW     (MW)
  ) u_lanes (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_accum  (w_accum),
    .i_tree   (w_tree),
    .i_beat   (r_beat),
    .i_live   (r_live),
    .i_nums   (r_nums),
    .o_acc0_d (w_acc0_d)
  );

  assign io_bus.busy = (r_state == StAccum) || (r_state == StTree);
  assign io_bus.done = (r_state == StDone);
  assign io_bus.sum  = r_sum;

endmodule

// File: tb/tb_sum_nk_reducer.sv
// Directed bench for sum_nk_reducer: default, signed and corner-parameter instances.
module tb_sum_nk_reducer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_nk_reducer_if #(.N(50), .W(5)) if_def ();
  sum_nk_reducer_if #(.N(50), .W(5)) if_sg  ();
  sum_nk_reducer_if #(.N(1),  .W(8)) if_a   ();
  sum_nk_reducer_if #(.N(7),  .W(8)) if_b   ();
  sum_nk_reducer_if #(.N(8),  .W(8)) if_c   ();

  sum_nk_reducer #(.N(50), .W(5), .P(9), .SIGNED(1'b0)) u_def (
    .clk(clk), .rst_n(rst_n), .io_bus(if_def));
  sum_nk_reducer #(.N(50), .W(5), .P(9), .SIGNED(1'b1)) u_sg (
    .clk(clk), .rst_n(rst_n), .io_bus(if_sg));
  sum_nk_reducer #(.N(1), .W(8), .P(1), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .io_bus(if_a));
  sum_nk_reducer #(.N(7), .W(8), .P(1), .SIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .io_bus(if_b));
  sum_nk_reducer #(.N(8), .W(8), .P(8), .SIGNED(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .io_bus(if_c));

  int     sel = 0;
  logic   go  = 1'b0;
  int     n_cmp = 0;
  int     n_err = 0;

  assign if_def.start = go && (sel == 0);
  assign if_sg.start  = go && (sel == 1);
  assign if_a.start   = go && (sel == 2);
  assign if_b.start   = go && (sel == 3);
  assign if_c.start   = go && (sel == 4);

  logic   m_busy;
  logic   m_done;
  longint m_sum;

  always_comb begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_sum  = 0;
    case (sel)
      0: begin m_busy = if_def.busy; m_done = if_def.done; m_sum = longint'(if_def.sum); end
      1: begin m_busy = if_sg.busy;  m_done = if_sg.done;  m_sum = longint'(if_sg.sum);  end
      2: begin m_busy = if_a.busy;   m_done = if_a.done;   m_sum = longint'(if_a.sum);   end
      3: begin m_busy = if_b.busy;   m_done = if_b.done;   m_sum = longint'(if_b.sum);   end
      4: begin m_busy = if_c.busy;   m_done = if_c.done;   m_sum = longint'(if_c.sum);   end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Start pulse; returns just after the accepting edge (edge 0).
  task automatic pulse();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Watches one operation from just after edge 0; optionally keeps start high
  // while busy and rewrites the default operands after acceptance.
  task automatic observe(input string tag, input int lat, input longint exp_sum,
                         input bit hold, input bit rewrite);
    int     busy_n  = 0;
    int     done_n  = 0;
    int     done_at = -1;
    longint sum_at  = -1;
    if (rewrite) if_def.nums = '0;
    for (int e = 0; e <= lat + 4; e++) begin
      if (e > 0) @(negedge clk);
      if (m_busy) busy_n++;
      if (m_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = e;
          sum_at  = m_sum;
        end
      end
      if (hold) go = m_busy;
    end
    go = 1'b0;
    check_eq({tag, "_lat"},   done_at, lat);
    check_eq({tag, "_dones"}, done_n,  1);
    check_eq({tag, "_busy"},  busy_n,  lat);
    check_eq({tag, "_sum"},   sum_at,  exp_sum);
  endtask

  task automatic run_op(input string tag, input int lat, input longint exp_sum);
    pulse();
    observe(tag, lat, exp_sum, 1'b0, 1'b0);
  endtask

  task automatic fill_def(input logic [4:0] v);
    for (int k = 0; k < 50; k++) if_def.nums[k*5 +: 5] = v;
  endtask

  initial begin
    int     t;
    int     dn;
    int     s;
    longint exp;
    logic [7:0] v;

    if_def.nums = '0;
    if_sg.nums  = '0;
    if_a.nums   = '0;
    if_b.nums   = '0;
    if_c.nums   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", m_busy, 0);
    check_eq("rst_done", m_done, 0);
    check_eq("rst_sum",  m_sum,  0);
    rst_n = 1'b1;

    // 50 x 31
    fill_def(5'd31);
    run_op("all31", 10, 1550);

    // k mod 32: 0..31 -> 496, 0..17 -> 153
    for (int k = 0; k < 50; k++) if_def.nums[k*5 +: 5] = 5'(k % 32);
    run_op("ramp", 10, 649);

    // start held while busy, operands cleared after acceptance
    fill_def(5'd31);
    pulse();
    observe("hold", 10, 1550, 1'b1, 1'b1);

    // back-to-back: second start in the DONE cycle
    fill_def(5'd31);
    pulse();
    t = 0;
    while (!m_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("b2b_first_lat",  t,      10);
    check_eq("b2b_first_done", m_done, 1);
    check_eq("b2b_first_sum",  m_sum,  1550);
    fill_def(5'd1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    observe("b2b", 10, 50, 1'b0, 1'b0);

    // reset at edge 5 of an operation
    fill_def(5'd31);
    pulse();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", m_busy, 0);
    check_eq("abort_done", m_done, 0);
    check_eq("abort_sum",  m_sum,  0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    check_eq("abort_no_done", dn, 0);
    run_op("after_rst", 10, 1550);

    // signed: 50 x -16 = -800 -> 11-bit 0x4E0
    sel = 1;
    for (int k = 0; k < 50; k++) if_sg.nums[k*5 +: 5] = 5'b10000;
    run_op("sg_min", 10, 1248);

    s = 0;
    for (int k = 0; k < 50; k++) begin
      if_sg.nums[k*5 +: 5] = 5'((k % 32) - 16);
      s += (k % 32) - 16;
    end
    exp = longint'(s) & 64'd2047;
    run_op("sg_ramp", 10, exp);

    // corner parameters with random operands
    sel = 2;
    v = 8'($urandom);
    if_a.nums = v;
    run_op("n1p1", 1, longint'(v));

    sel = 3;
    exp = 0;
    for (int k = 0; k < 7; k++) begin
      v = 8'($urandom);
      if_b.nums[k*8 +: 8] = v;
      exp += longint'(v);
    end
    run_op("n7p1", 7, exp);

    sel = 4;
    exp = 0;
    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom);
      if_c.nums[k*8 +: 8] = v;
      exp += longint'(v);
    end
    run_op("n8p8", 4, exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
